// File: rtl/bloom_multi_matcher_pkg.sv
// Shared definitions for the Bloom multi-filter matcher: FSM encoding,
// hash rotation constants and a constant-time log2 helper.
package bloom_multi_matcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_HEADER  = 3'b010,
        ST_PAYLOAD = 3'b100
    } state_t;

    localparam int HASH_ROT_MUL = 7;
    localparam int HASH_ROT_ADD = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bloom_multi_matcher_hash_check.sv
// Combinational membership test of one word against one Bloom filter:
// HASH_K rotate-and-fold hashes, hit only when every indexed bit is set.
module bloom_multi_matcher_hash_check
    import bloom_multi_matcher_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int FILTER_W = 64,
    parameter int HASH_K   = 2
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [FILTER_W-1:0] filter,
    output logic                hit
);
    localparam int IDX_W  = clog2(FILTER_W);
    localparam int NSLICE = (DATA_W + IDX_W - 1) / IDX_W;
    localparam int PAD_W  = NSLICE * IDX_W;

    logic [HASH_K-1:0] hash_hits;

    for (genvar gi = 0; gi < HASH_K; gi++) begin : g_hash
        localparam int ROT = (HASH_ROT_MUL * gi + HASH_ROT_ADD) % DATA_W;

        logic [DATA_W-1:0] rotated;
        logic [PAD_W-1:0]  padded;
        logic [IDX_W-1:0]  idx;

        assign rotated = (data << ROT) | (data >> (DATA_W - ROT));
        // Zero-extension pads the final, partial slice before folding.
        assign padded  = PAD_W'(rotated);

        always_comb begin
            idx = '0;
            for (int s = 0; s < NSLICE; s++) begin
                idx = idx ^ padded[s*IDX_W +: IDX_W];
            end
        end

        assign hash_hits[gi] = filter[idx];
    end

    assign hit = &hash_hits;

endmodule

// File: rtl/bloom_multi_matcher.sv
// Packet-framed Bloom matcher: snapshots NUM_FILTERS filters at packet start,
// ORs per-word hits over the payload and issues a verdict after EOP.
module bloom_multi_matcher
    import bloom_multi_matcher_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int CTRL_W      = 8,
    parameter int HDR_WORDS   = 3,
    parameter int NUM_FILTERS = 4,
    parameter int FILTER_W    = 64,
    parameter int HASH_K      = 2,
    parameter int CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_wr,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [CTRL_W-1:0]               in_ctrl,
    input  logic [NUM_FILTERS*FILTER_W-1:0] filters,
    output logic                            result_valid,
    output logic [NUM_FILTERS-1:0]          match_vec,
    output logic                            runt,
    output logic [CNT_W-1:0]                pkt_count,
    output logic [CNT_W-1:0]                hit_count
);
    state_t                          state;
    logic [3:0]                      hdr_cnt;
    logic [NUM_FILTERS-1:0]          sticky;
    logic [NUM_FILTERS*FILTER_W-1:0] filters_q;
    logic [NUM_FILTERS-1:0]          hit_vec;
    logic                            ctrl_nz;
    logic                            hdr_last;
    logic                            fire;
    logic                            fire_runt;

    for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_filter
        bloom_multi_matcher_hash_check #(
            .DATA_W   (DATA_W),
            .FILTER_W (FILTER_W),
            .HASH_K   (HASH_K)
        ) u_check (
            .data   (in_data),
            .filter (filters_q[gi*FILTER_W +: FILTER_W]),
            .hit    (hit_vec[gi])
        );
    end

    assign ctrl_nz  = |in_ctrl;
    assign hdr_last = ({1'b0, hdr_cnt} + 5'd1) == 5'(HDR_WORDS);

    // A framing word seen inside a packet always closes it; in HEADER it is a runt.
    always_comb begin
        fire      = 1'b0;
        fire_runt = 1'b0;
        if (in_wr && ctrl_nz) begin
            if (state == ST_HEADER) begin
                fire      = 1'b1;
                fire_runt = 1'b1;
            end else if (state == ST_PAYLOAD) begin
                fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            hdr_cnt      <= '0;
            sticky       <= '0;
            filters_q    <= '0;
            result_valid <= 1'b0;
            match_vec    <= '0;
            runt         <= 1'b0;
            pkt_count    <= '0;
            hit_count    <= '0;
        end else begin
            result_valid <= fire;
            if (fire) begin
                match_vec <= fire_runt ? '0 : sticky;
                runt      <= fire_runt;
                if (pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
                if (!fire_runt && (sticky != '0) && (hit_count != '1))
                    hit_count <= hit_count + CNT_W'(1);
            end
            if (in_wr) begin
                case (state)
                    ST_IDLE: begin
                        if (ctrl_nz) begin
                            state     <= ST_HEADER;
                            filters_q <= filters;
                            sticky    <= '0;
                            hdr_cnt   <= '0;
                        end
                    end
                    ST_HEADER: begin
                        if (ctrl_nz) begin
                            state <= ST_IDLE;
                        end else begin
                            hdr_cnt <= hdr_cnt + 4'd1;
                            if (hdr_last) state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (ctrl_nz) state <= ST_IDLE;
                        else         sticky <= sticky | hit_vec;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bloom_multi_matcher.sv
// Directed bench for bloom_multi_matcher: packet-level reference model plus
// hand-computed literal checks, compared every cycle one step after the clock edge.
module tb_bloom_multi_matcher;
    localparam int HDR = 3;
    localparam logic [63:0] WORD  = 64'hDEADBEEF_00000001;
    localparam logic [63:0] F0HIT = (64'd1 << 28) | (64'd1 << 16);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_wr = 1'b0;
    logic [63:0]  in_data = '0;
    logic [7:0]   in_ctrl = '0;
    logic [255:0] filters = '0;

    logic         result_valid, runt;
    logic [3:0]   match_vec;
    logic [15:0]  pkt_count, hit_count;
    logic         s_valid, s_runt;
    logic [3:0]   s_match;
    logic [3:0]   s_pkt, s_hit;

    bloom_multi_matcher dut (
        .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_ctrl(in_ctrl),
        .filters(filters), .result_valid(result_valid), .match_vec(match_vec),
        .runt(runt), .pkt_count(pkt_count), .hit_count(hit_count)
    );

    bloom_multi_matcher #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_ctrl(in_ctrl),
        .filters(filters), .result_valid(s_valid), .match_vec(s_match),
        .runt(s_runt), .pkt_count(s_pkt), .hit_count(s_hit)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Reference model state: packet words collected since the start word.
    bit           in_pkt = 1'b0;
    logic [63:0]  words[$];
    logic [255:0] snap = '0;
    logic         exp_valid = 1'b0, exp_runt = 1'b0;
    logic [3:0]   exp_match = '0;
    int           exp_pkt = 0, exp_hit = 0, exp_spkt = 0, exp_shit = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Bit b of the word lands at (b+rot) mod 64 after rotation, then folds into idx bit by mod 6.
    function automatic logic [5:0] hidx(input logic [63:0] d, input int j);
        logic [5:0] idx;
        int rot;
        idx = '0;
        rot = (7 * j + 1) % 64;
        for (int b = 0; b < 64; b++) idx[((b + rot) % 64) % 6] ^= d[b];
        return idx;
    endfunction

    function automatic bit word_hits(input logic [255:0] fb, input int f, input logic [63:0] d);
        return fb[f*64 + hidx(d, 0)] && fb[f*64 + hidx(d, 1)];
    endfunction

    task automatic model_reset();
        in_pkt = 1'b0; words.delete();
        exp_valid = 1'b0; exp_runt = 1'b0; exp_match = '0;
        exp_pkt = 0; exp_hit = 0; exp_spkt = 0; exp_shit = 0;
    endtask

    task automatic model(input logic wr, input logic [7:0] ctrl, input logic [63:0] data);
        logic [3:0] m;
        exp_valid = 1'b0;
        if (!wr) return;
        if (!in_pkt) begin
            if (ctrl != 0) begin
                in_pkt = 1'b1; snap = filters; words.delete();
            end
        end else if (ctrl == 0) begin
            words.push_back(data);
        end else begin
            in_pkt = 1'b0;
            exp_valid = 1'b1;
            m = '0;
            exp_runt = (words.size() < HDR);
            for (int k = HDR; k < words.size(); k++)
                for (int f = 0; f < 4; f++)
                    if (word_hits(snap, f, words[k])) m[f] = 1'b1;
            exp_match = m;
            if (exp_pkt < 65535) exp_pkt++;
            if (exp_spkt < 15) exp_spkt++;
            if (m != 0 && exp_hit < 65535) exp_hit++;
            if (m != 0 && exp_shit < 15) exp_shit++;
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] ctrl, input logic [63:0] data);
        @(negedge clk);
        in_wr = wr; in_ctrl = ctrl; in_data = data;
        model(wr, ctrl, data);
    endtask

    task automatic hdr3();
        for (int i = 1; i <= HDR; i++) step(1'b1, 8'h00, 64'h1111 * i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_wr = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", result_valid, 0);
        chk("rst_match", match_vec, 0);
        chk("rst_runt", runt, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_hit", hit_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (checking) begin
            chk("result_valid", result_valid, exp_valid);
            chk("match_vec", match_vec, exp_match);
            chk("runt", runt, exp_runt);
            chk("pkt_count", pkt_count, exp_pkt);
            chk("hit_count", hit_count, exp_hit);
            chk("small_valid", s_valid, exp_valid);
            chk("small_pkt", s_pkt, exp_spkt);
            chk("small_hit", s_hit, exp_shit);
        end
    end

    initial begin
        chk("hash0_literal", hidx(WORD, 0), 28);
        chk("hash1_literal", hidx(WORD, 1), 16);
        do_reset();
        checking = 1'b1;

        // 1: single hitting payload word in filter 0
        filters = {192'd0, F0HIT};
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h00, WORD);
        step(1'b1, 8'h80, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t1_match", match_vec, 4'b0001);
        chk("t1_pkt", pkt_count, 1);
        chk("t1_hit", hit_count, 1);

        // 2: runt after one header word
        do_reset();
        step(1'b1, 8'h01, 64'h0); step(1'b1, 8'h00, 64'h5);
        step(1'b1, 8'h40, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t2_runt", runt, 1);
        chk("t2_match", match_vec, 0);
        chk("t2_pkt", pkt_count, 1);
        chk("t2_hit", hit_count, 0);

        // 3: all-ones filters, empty payload then two payload words
        do_reset();
        filters = '1;
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h80, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t3_empty_match", match_vec, 0);
        chk("t3_empty_runt", runt, 0);
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h00, 64'h0123_4567_89AB_CDEF);
        step(1'b1, 8'h00, 64'h0);
        step(1'b1, 8'h80, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t3_full_match", match_vec, 4'hF);

        // 4: back-to-back packets, second one misses
        do_reset();
        filters = {192'd0, F0HIT};
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h00, WORD);
        step(1'b1, 8'h80, 64'h0);
        step(1'b1, 8'h01, 64'h0);
        chk("t4_first_match", match_vec, 4'b0001);
        hdr3();
        step(1'b1, 8'h00, 64'h0);
        step(1'b1, 8'h80, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t4_second_match", match_vec, 0);
        chk("t4_hit", hit_count, 1);
        chk("t4_pkt", pkt_count, 2);

        // 5: filters cleared mid-payload, bubbles carrying framing-looking junk
        do_reset();
        filters = {192'd0, F0HIT};
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h00, WORD);
        step(1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        filters = '0;
        step(1'b0, 8'h80, 64'h0);
        step(1'b1, 8'h00, 64'h0);
        step(1'b1, 8'h80, 64'h0);
        step(1'b0, 8'h00, 64'h0);
        chk("t5_match", match_vec, 4'b0001);
        chk("t5_pkt", pkt_count, 1);

        // 6: reset mid-payload discards the packet, then counter saturation
        filters = {192'd0, F0HIT};
        step(1'b1, 8'h01, 64'h0); hdr3();
        step(1'b1, 8'h00, WORD);
        do_reset();
        step(1'b0, 8'h00, 64'h0);
        for (int p = 0; p < 20; p++) begin
            step(1'b1, 8'h01, 64'h0); hdr3();
            step(1'b1, 8'h80, 64'h0);
        end
        step(1'b0, 8'h00, 64'h0);
        chk("t6_small_pkt", s_pkt, 15);
        chk("t6_pkt", pkt_count, 20);
        chk("t6_hit", hit_count, 0);

        step(1'b0, 8'h00, 64'h0);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
